// File: rtl/sobel_frame_sequencer.sv
// rtl/sobel_frame_sequencer.sv - frame sequencer for a 3x3 Sobel line-buffer datapath
//
// Sequences one frame through FILL (prime IMG_W+1 pixels), STREAM (one centre
// output per accepted pixel) and FLUSH (IMG_W+1 zero-fed shifts to drain the
// last centres). It produces the shift/valid controls and centre coordinates.
//
// Ports:
//   iCLK         clock, rising edge
//   iRST         asynchronous active-low reset
//   iSTART       single-cycle frame-start request (honoured in IDLE only)
//   iDVAL        upstream pixel valid
//   oSHIFT_EN    advance the line-buffer shift register this cycle
//   oZERO_IN     shift in 0 instead of the pixel (FLUSH only)
//   oDVAL        kernel centre pixel valid this cycle
//   oX, oY       kernel centre column / row
//   oEDGE_*      border flags of the current centre (valid with oDVAL)
//   oBUSY        high outside IDLE
//   oFRAME_DONE  one-cycle pulse after the last output pixel
module sobel_frame_sequencer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iSTART,
    input  logic                     iDVAL,
    output logic                     oSHIFT_EN,
    output logic                     oZERO_IN,
    output logic                     oDVAL,
    output logic [$clog2(IMG_W)-1:0] oX,
    output logic [$clog2(IMG_H)-1:0] oY,
    output logic                     oEDGE_N,
    output logic                     oEDGE_S,
    output logic                     oEDGE_W,
    output logic                     oEDGE_E,
    output logic                     oBUSY,
    output logic                     oFRAME_DONE
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W * IMG_H);
    localparam int FW = $clog2(IMG_W + 1);

    localparam logic [CW-1:0] PRIME_IDX = CW'(IMG_W);
    localparam logic [CW-1:0] LAST_IDX  = CW'(IMG_W * IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_END = FW'(IMG_W);
    localparam logic [XW-1:0] X_MAX     = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_in_cnt;
    logic [FW-1:0] r_flush_cnt;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_frame_done;

    logic w_accept;
    logic w_out;

    // Controls follow iDVAL in the same cycle, so they are decoded from the
    // registered state rather than registered themselves; reset forcing IDLE
    // therefore drops them immediately.
    assign w_accept = iDVAL && (r_state == S_FILL || r_state == S_STREAM);
    assign w_out    = (r_state == S_STREAM && iDVAL) || (r_state == S_FLUSH);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state      <= S_IDLE;
            r_in_cnt     <= '0;
            r_flush_cnt  <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A pixel coincident with iSTART is not accepted.
                    if (iSTART) begin
                        r_state  <= S_FILL;
                        r_in_cnt <= '0;
                        r_x      <= '0;
                        r_y      <= '0;
                    end
                end
                S_FILL: begin
                    if (iDVAL) begin
                        r_in_cnt <= r_in_cnt + CW'(1);
                        if (r_in_cnt == PRIME_IDX)
                            r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (iDVAL) begin
                        if (r_in_cnt == LAST_IDX) begin
                            r_state     <= S_FLUSH;
                            r_in_cnt    <= '0;
                            r_flush_cnt <= '0;
                        end else begin
                            r_in_cnt <= r_in_cnt + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == FLUSH_END) begin
                        r_state      <= S_IDLE;
                        r_flush_cnt  <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Centre coordinates step after every qualified output.
            if (w_out) begin
                if (r_x == X_MAX) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_MAX) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    assign oSHIFT_EN   = w_accept || (r_state == S_FLUSH);
    assign oZERO_IN    = (r_state == S_FLUSH);
    assign oDVAL       = w_out;
    assign oX          = r_x;
    assign oY          = r_y;
    assign oEDGE_N     = (r_y == '0);
    assign oEDGE_S     = (r_y == Y_MAX);
    assign oEDGE_W     = (r_x == '0);
    assign oEDGE_E     = (r_x == X_MAX);
    assign oBUSY       = (r_state != S_IDLE);
    assign oFRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb/tb_sobel_frame_sequencer.sv - self-checking bench for sobel_frame_sequencer (4x3 frame)
module tb_sobel_frame_sequencer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       iCLK;
    logic       iRST;
    logic       iSTART;
    logic       iDVAL;
    logic       oSHIFT_EN;
    logic       oZERO_IN;
    logic       oDVAL;
    logic [1:0] oX;
    logic [1:0] oY;
    logic       oEDGE_N;
    logic       oEDGE_S;
    logic       oEDGE_W;
    logic       oEDGE_E;
    logic       oBUSY;
    logic       oFRAME_DONE;

    sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSTART     (iSTART),
        .iDVAL      (iDVAL),
        .oSHIFT_EN  (oSHIFT_EN),
        .oZERO_IN   (oZERO_IN),
        .oDVAL      (oDVAL),
        .oX         (oX),
        .oY         (oY),
        .oEDGE_N    (oEDGE_N),
        .oEDGE_S    (oEDGE_S),
        .oEDGE_W    (oEDGE_W),
        .oEDGE_E    (oEDGE_E),
        .oBUSY      (oBUSY),
        .oFRAME_DONE(oFRAME_DONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic [3:0] nswe;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected centres of one frame, raster order; the last W+1 come from FLUSH.
    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.x    = 2'(i % W);
            e.y    = 2'(i / W);
            e.nswe = {e.y == 2'd0, e.y == 2'(H - 1), e.x == 2'd0, e.x == 2'(W - 1)};
            e.zero = (i >= N - (W + 1));
            sb.push_back(e);
        end
    endtask

    // Scoreboard consumer: every qualified output pops one expected centre.
    always @(negedge iCLK) begin
        if (iRST && oDVAL) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_x", 32'(oX), 32'(e.x));
                check("out_y", 32'(oY), 32'(e.y));
                check("out_edges", 32'({oEDGE_N, oEDGE_S, oEDGE_W, oEDGE_E}), 32'(e.nswe));
                check("out_zero_in", 32'(oZERO_IN), 32'(e.zero));
            end
        end
    end

    // gap: 0 back-to-back, 1 every other cycle. mid_start: pulse iSTART mid-STREAM.
    // abort_flush: FLUSH cycle index (0-based) at which to assert reset, -1 none.
    task automatic run_frame(input int gap, input bit mid_start, input int abort_flush);
        int idx;
        int cyc;
        logic dv;
        @(posedge iCLK); #1;
        iSTART = 1'b1;
        iDVAL  = 1'b1;
        push_frame();
        @(negedge iCLK);
        check("start_no_shift", 32'(oSHIFT_EN), 32'(0));
        check("start_idle_busy", 32'(oBUSY), 32'(0));
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 200) begin
            dv     = (gap == 0) ? 1'b1 : logic'(cyc % 2);
            iDVAL  = dv;
            iSTART = mid_start && (idx == 8);
            @(negedge iCLK);
            check("in_shift_en", 32'(oSHIFT_EN), 32'(dv));
            check("in_dval", 32'(oDVAL), 32'(dv && idx >= W + 1));
            check("in_zero_in", 32'(oZERO_IN), 32'(0));
            check("in_busy", 32'(oBUSY), 32'(1));
            @(posedge iCLK); #1;
            if (dv) idx++;
            cyc++;
        end
        check("in_cycle_budget", 32'(idx), 32'(N));
        iSTART = 1'b0;
        for (int k = 0; k <= W; k++) begin
            iDVAL = logic'($urandom_range(0, 1));
            @(negedge iCLK);
            check("fl_shift_en", 32'(oSHIFT_EN), 32'(1));
            check("fl_zero_in", 32'(oZERO_IN), 32'(1));
            check("fl_dval", 32'(oDVAL), 32'(1));
            check("fl_busy", 32'(oBUSY), 32'(1));
            if (k == abort_flush) begin
                #2 iRST = 1'b0;
                #1;
                check("rst_outs", 32'({oSHIFT_EN, oZERO_IN, oDVAL, oBUSY, oFRAME_DONE}), 32'(0));
                check("rst_xy", 32'({oX, oY}), 32'(0));
                @(posedge iCLK); #1;
                iRST  = 1'b1;
                iDVAL = 1'b0;
                sb.delete();
                for (int j = 0; j < 4; j++) begin
                    @(negedge iCLK);
                    check("abort_no_done", 32'(oFRAME_DONE), 32'(0));
                    check("abort_idle", 32'(oBUSY), 32'(0));
                end
                return;
            end
            @(posedge iCLK); #1;
        end
        iDVAL = 1'b0;
        @(negedge iCLK);
        check("done_pulse", 32'(oFRAME_DONE), 32'(1));
        check("done_busy_low", 32'(oBUSY), 32'(0));
        check("done_no_dval", 32'(oDVAL), 32'(0));
        @(negedge iCLK);
        check("done_one_cycle", 32'(oFRAME_DONE), 32'(0));
        check("sb_drained", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        iRST   = 1'b0;
        iSTART = 1'b0;
        iDVAL  = 1'b0;
        repeat (2) @(negedge iCLK);
        check("reset_outs", 32'({oSHIFT_EN, oZERO_IN, oDVAL, oBUSY, oFRAME_DONE}), 32'(0));
        check("reset_xy", 32'({oX, oY}), 32'(0));
        @(posedge iCLK); #1;
        iRST = 1'b1;

        // iDVAL pulses in IDLE must not shift or produce output.
        for (int i = 0; i < 3; i++) begin
            @(posedge iCLK); #1;
            iDVAL = 1'b1;
            @(negedge iCLK);
            check("idle_no_shift", 32'(oSHIFT_EN), 32'(0));
            check("idle_no_dval", 32'(oDVAL), 32'(0));
            check("idle_busy", 32'(oBUSY), 32'(0));
        end

        run_frame(0, 1'b0, -1);
        run_frame(1, 1'b0, -1);
        run_frame(0, 1'b1, -1);
        run_frame(0, 1'b0, 1);
        run_frame(0, 1'b0, -1);

        repeat (2) @(posedge iCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_frame_sequencer.md
SOBEL_FRAME_SEQUENCER -- requirements
Module: sobel_frame_sequencer

Interface
REQ-001 SHALL provide parameter IMG_W, default 640, meaning active pixels per line.
REQ-002 SHALL provide parameter IMG_H, default 480, meaning lines per frame.
REQ-003 SHALL have port iCLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port iRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iSTART  input  1  single-cycle frame-start request.
REQ-006 SHALL have port iDVAL  input  1  grayscale pixel valid from the upstream converter.
REQ-007 SHALL have port oSHIFT_EN  output  1  advance the line-buffer shift register this cycle.
REQ-008 SHALL have port oZERO_IN  output  1  datapath shifts in 0 instead of the pixel (flush).
REQ-009 SHALL have port oDVAL  output  1  the kernel centre pixel is valid this cycle.
REQ-010 SHALL have port oX  output  $clog2(IMG_W)  kernel centre column.
REQ-011 SHALL have port oY  output  $clog2(IMG_H)  kernel centre row.
REQ-012 SHALL have ports oEDGE_N, oEDGE_S, oEDGE_W, oEDGE_E  output  1 each  border flags.
REQ-013 SHALL have port oBUSY  output  1  high in any state other than IDLE.
REQ-014 SHALL have port oFRAME_DONE  output  1  one-cycle pulse after the last output pixel.

Function
REQ-015 SHALL implement the states IDLE, FILL, STREAM and FLUSH.
REQ-016 IDLE: iDVAL ignored, oSHIFT_EN=0; iSTART -> FILL with the input counter, oX and oY cleared.
REQ-017 Input counter IN_CNT (0 to IMG_W*IMG_H-1) SHALL increment on each accepted iDVAL in FILL and STREAM.
REQ-018 FILL: oSHIFT_EN=iDVAL, oDVAL=0; the cycle accepting pixel index IMG_W -> STREAM (IMG_W+1 pixels primed).
REQ-019 STREAM: oSHIFT_EN=iDVAL, oDVAL=iDVAL; target index = IN_CNT-(IMG_W+1), so latency is fixed at IMG_W+1 accepted pixels.
REQ-020 STREAM: the cycle accepting pixel index IMG_W*IMG_H-1 -> FLUSH.
REQ-021 FLUSH: oSHIFT_EN=1, oZERO_IN=1, oDVAL=1 every cycle, iDVAL ignored, for exactly IMG_W+1 cycles.
REQ-022 The last FLUSH cycle (target IMG_W*IMG_H-1) SHALL go to IDLE with oFRAME_DONE=1 on the following cycle.
REQ-023 oZERO_IN SHALL be 0 in every state other than FLUSH.
REQ-024 oX/oY SHALL be the registered coordinates of the pixel qualified by oDVAL, advanced after each oDVAL cycle.
REQ-025 oX SHALL wrap from IMG_W-1 to 0 and increment oY; incremental counters, no divide or modulo.
REQ-026 Edge flags: oEDGE_N = (oY==0), oEDGE_S = (oY==IMG_H-1), oEDGE_W = (oX==0), oEDGE_E = (oX==IMG_W-1); combinational, valid when oDVAL=1.
REQ-027 iSTART outside IDLE SHALL be ignored; a frame in progress is never restarted.
REQ-028 iSTART coincident with iDVAL in IDLE SHALL start the frame without accepting that pixel.
REQ-029 oBUSY SHALL be high in FILL, STREAM and FLUSH and low in IDLE, including the oFRAME_DONE cycle.

Reset
REQ-030 iRST low SHALL immediately force IDLE, IN_CNT=0, oX=0, oY=0, flush counter=0.
REQ-031 During reset: oSHIFT_EN, oZERO_IN, oDVAL, oBUSY and oFRAME_DONE = 0.
REQ-032 Reset mid-frame SHALL discard the frame with no oFRAME_DONE; the next iSTART begins cleanly.

Verification (IMG_W=4, IMG_H=3)
REQ-033 Full frame: iSTART, then 12 back-to-back iDVAL -> oDVAL first high on pixel index 5 at (0,0); 7 STREAM outputs, 5 FLUSH outputs ending at (3,2); oFRAME_DONE one cycle later.
REQ-034 Gapped input: iDVAL every other cycle -> oSHIFT_EN and oDVAL mirror iDVAL in STREAM; coordinate sequence is identical to REQ-033.
REQ-035 Edge flags: check each of 12 outputs; (0,0) N+W, (3,0) N+E, (1,1) none, (0,2) S+W, (3,2) S+E.
REQ-036 iDVAL pulses in IDLE, then iSTART mid-STREAM -> no shifts in IDLE; iSTART ignored; frame completes normally.
REQ-037 iRST low during FLUSH cycle 2 -> all outputs 0 asynchronously, no oFRAME_DONE; a new full frame then matches REQ-033.
